fish_scheduler: RTL

FISH_SCHEDULER -- requirements
Module: fish_scheduler

---
 rtl/fish_scheduler.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/fish_scheduler.sv
// fish_scheduler
//   Move-tick generator, pseudo-random spawner and four-slot fish tracker for
//   a fishing game. Each slot owns a small FSM (IDLE / SWIM / HOOKED) plus a
//   direction, an x position and a y position.
//
// Ports
//   clk            system clock, all state on the rising edge
//   rst            asynchronous active-low reset
//   enable         game running; gates tick generation (and so motion/spawn)
//   hook_req       request to hook slot hook_slot, sampled every cycle
//   hook_slot      target slot 0..3
//   reel_done      hooked fish delivered; frees the HOOKED slot
//   tick           one-cycle move-tick pulse (combinational from counter)
//   hook_ack       one-cycle pulse, the cycle after an accepted hook_req
//   hook_nack      one-cycle pulse, the cycle after a rejected hook_req
//   appear         bit i set while slot i is not IDLE
//   way            2 bits per slot: 0 left, 1 right, 2 up (hooked)
//   fish_x         10 bits per slot
//   fish_y         9 bits per slot
//   slot_state_dbg 2 bits per slot, raw slot FSM state
//
// Hook handshake: every cycle with hook_req=1 is one request, judged against
// the state registered at the start of that cycle; exactly one of
// hook_ack / hook_nack pulses in the following cycle. A held request is
// therefore re-judged each cycle (the second cycle of a held accepted request
// sees the slot already HOOKED and is nacked).
module fish_scheduler #(
    parameter int TICK_MAX  = 2500000,
    parameter int SPAWN_GAP = 40,
    parameter int X_MAX     = 640
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        hook_req,
    input  logic [1:0]  hook_slot,
    input  logic        reel_done,
    output logic        tick,
    output logic        hook_ack,
    output logic        hook_nack,
    output logic [3:0]  appear,
    output logic [7:0]  way,
    output logic [39:0] fish_x,
    output logic [35:0] fish_y,
    output logic [7:0]  slot_state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SWIM   = 2'd1,
        S_HOOKED = 2'd2
    } slot_state_e;

    localparam logic [23:0] TICK_LAST = 24'(TICK_MAX);
    localparam logic [5:0]  GAP_LAST  = 6'(SPAWN_GAP - 1);
    localparam logic [9:0]  X_LAST    = 10'(X_MAX - 1);

    logic [23:0] cnt_q, cnt_d;
    logic [5:0]  gap_q, gap_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        ack_q, ack_d;
    logic        nack_q, nack_d;
    slot_state_e state_q [4];
    slot_state_e state_d [4];
    logic [1:0]  way_q [4];
    logic [1:0]  way_d [4];
    logic [9:0]  x_q [4];
    logic [9:0]  x_d [4];
    logic [8:0]  y_q [4];
    logic [8:0]  y_d [4];

    logic       any_hooked;
    logic       hook_ok;
    logic       have_idle;
    logic [1:0] idle_idx;
    logic       spawn;

    assign tick = enable && (cnt_q == TICK_LAST);

    always_comb begin
        cnt_d  = cnt_q;
        gap_d  = gap_q;
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        any_hooked = 1'b0;
        have_idle  = 1'b0;
        idle_idx   = 2'd0;
        spawn      = 1'b0;

        if (enable) begin
            cnt_d = tick ? 24'd0 : cnt_q + 24'd1;
        end

        // Scan downwards so the lowest-index IDLE slot is the one left in idle_idx.
        for (int i = 3; i >= 0; i--) begin
            if (state_q[i] == S_HOOKED) begin
                any_hooked = 1'b1;
            end
            if (state_q[i] == S_IDLE) begin
                have_idle = 1'b1;
                idle_idx  = 2'(i);
            end
        end

        hook_ok = hook_req && (state_q[hook_slot] == S_SWIM) && !any_hooked;
        ack_d   = hook_ok;
        nack_d  = hook_req && !hook_ok;

        // At the last gap value the counter parks until a slot is free; the
        // candidate set is the pre-cycle IDLE set, so a slot freed this cycle
        // waits for a later tick.
        if (tick) begin
            if (gap_q == GAP_LAST) begin
                if (have_idle) begin
                    spawn = 1'b1;
                    gap_d = 6'd0;
                end
            end else begin
                gap_d = gap_q + 6'd1;
            end
        end

        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            way_d[i]   = way_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (spawn && (idle_idx == 2'(i))) begin
                        state_d[i] = S_SWIM;
                        way_d[i]   = {1'b0, lfsr_q[0]};
                        x_d[i]     = lfsr_q[0] ? 10'd0 : X_LAST;
                        y_d[i]     = 9'd64 + {1'b0, lfsr_q[8:1]};
                    end
                end
                S_SWIM: begin
                    // An accepted hook beats the tick: no step, no edge exit.
                    if (hook_ok && (hook_slot == 2'(i))) begin
                        state_d[i] = S_HOOKED;
                        way_d[i]   = 2'd2;
                    end else if (tick) begin
                        if (way_q[i] == 2'd1) begin
                            if (x_q[i] == X_LAST) state_d[i] = S_IDLE;
                            else                  x_d[i] = x_q[i] + 10'd1;
                        end else begin
                            if (x_q[i] == 10'd0) state_d[i] = S_IDLE;
                            else                 x_d[i] = x_q[i] - 10'd1;
                        end
                    end
                end
                S_HOOKED: begin
                    if (reel_done) begin
                        state_d[i] = S_IDLE;
                    end else if (tick && (y_q[i] != 9'd0)) begin
                        y_d[i] = y_q[i] - 9'd1;
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= 24'd0;
            gap_q  <= 6'd0;
            lfsr_q <= 16'hACE1;
            ack_q  <= 1'b0;
            nack_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= S_IDLE;
                way_q[i]   <= 2'd0;
                x_q[i]     <= 10'd0;
                y_q[i]     <= 9'd0;
            end
        end else begin
            cnt_q  <= cnt_d;
            gap_q  <= gap_d;
            lfsr_q <= lfsr_d;
            ack_q  <= ack_d;
            nack_q <= nack_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                way_q[i]   <= way_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
            end
        end
    end

    always_comb begin
        appear         = '0;
        way            = '0;
        fish_x         = '0;
        fish_y         = '0;
        slot_state_dbg = '0;
        for (int i = 0; i < 4; i++) begin
            appear[i]                 = (state_q[i] != S_IDLE);
            way[2*i +: 2]             = way_q[i];
            fish_x[10*i +: 10]        = x_q[i];
            fish_y[9*i +: 9]          = y_q[i];
            slot_state_dbg[2*i +: 2]  = state_q[i];
        end
    end

    assign hook_ack  = ack_q;
    assign hook_nack = nack_q;

endmodule
